// File: rtl/ctl_in_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ctl_in_sequencer_pkg
// Shared definitions for the control-IN sequencer: FSM state encodings,
// the default control max packet size and endpoint number constants.
// No ports (package).
// ----------------------------------------------------------------------------
package ctl_in_sequencer_pkg;

    typedef enum logic [2:0] {
        CIS_IDLE    = 3'd0,
        CIS_WAIT_IN = 3'd1,
        CIS_XFER    = 3'd2,
        CIS_DRAIN   = 3'd3,
        CIS_DONE    = 3'd4
    } cis_state_e;

    localparam int         CIS_DEF_MAX_PACKET = 64;
    localparam logic [3:0] CIS_EP0            = 4'd0;
    localparam logic [3:0] CIS_EP_USER_DEF    = 4'd2;

endpackage

// File: rtl/ctl_in_sequencer.sv
// ----------------------------------------------------------------------------
// ctl_in_sequencer
// Shares the control-IN data path towards the transaction FSM between the
// pipe0 descriptor source (s0) and a user control endpoint source (s1).
// Per control transfer the source is chosen from the SETUP endpoint, the
// response is truncated to wLength and cut into MAX_PACKET_SIZE packets,
// one packet per IN token. Bytes beyond wLength are drained from the source.
//
// Ports:
//   clock, reset             clock, asynchronous active-low reset
//   start_i, endp_i, length_i SETUP strobe with endpoint and wLength
//   in_req_i                 IN token strobe for the control pipe
//   abort_i                  new SETUP / bus reset strobe (highest priority)
//   s0_* / s1_*              source streams (pipe0 ROM / user endpoint)
//   m_*                      output stream to the transaction FSM
//   busy_o, sel_o            transfer active, latched source select
//   done_o, zlp_o            data-stage complete strobe, ZLP-required strobe
//
// Build option: define USB_CTL_ZLP_EN to generate zlp_o; otherwise zlp_o
// is tied low and no ZLP logic exists.
// ----------------------------------------------------------------------------
module ctl_in_sequencer
    import ctl_in_sequencer_pkg::*;
#(
    parameter int         MAX_PACKET_SIZE = CIS_DEF_MAX_PACKET,
    parameter logic [3:0] EP_USER         = CIS_EP_USER_DEF,
    parameter int         USE_EP_USER     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [3:0]  endp_i,
    input  logic [15:0] length_i,
    input  logic        in_req_i,
    input  logic        abort_i,
    input  logic        s0_tvalid_i,
    output logic        s0_tready_o,
    input  logic        s0_tlast_i,
    input  logic [7:0]  s0_tdata_i,
    input  logic        s1_tvalid_i,
    output logic        s1_tready_o,
    input  logic        s1_tlast_i,
    input  logic [7:0]  s1_tdata_i,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        m_tlast_o,
    output logic [7:0]  m_tdata_o,
    output logic        busy_o,
    output logic        sel_o,
    output logic        done_o,
    output logic        zlp_o
);

    localparam int            CW         = $clog2(MAX_PACKET_SIZE) + 1;
    localparam logic [CW-1:0] CHUNK_LAST = CW'(MAX_PACKET_SIZE - 1);

    cis_state_e    state_r;
    cis_state_e    state_s;
    logic [15:0]   remaining_r;
    logic [CW-1:0] chunk_r;
    logic          sel_r;
    logic          src_end_r;   // selected source has delivered its tlast
    logic          aborted_r;   // transfer was aborted: finish silently

    logic          src_tvalid_s;
    logic          src_tlast_s;
    logic [7:0]    src_tdata_s;
    logic          src_tready_s;
    logic          last_rem_s;
    logic          last_chunk_s;
    logic          m_tlast_s;
    logic          xfer_hs_s;
    logic          drain_last_s;
    logic          src_end_now_s;

    // Selected-source view of the two input streams
    always_comb begin
        if (sel_r) begin
            src_tvalid_s = s1_tvalid_i;
            src_tlast_s  = s1_tlast_i;
            src_tdata_s  = s1_tdata_i;
        end else begin
            src_tvalid_s = s0_tvalid_i;
            src_tlast_s  = s0_tlast_i;
            src_tdata_s  = s0_tdata_i;
        end
    end

    assign last_rem_s    = (remaining_r == 16'd1);
    assign last_chunk_s  = (chunk_r == CHUNK_LAST);
    assign m_tlast_s     = src_tlast_s | last_chunk_s | last_rem_s;
    assign xfer_hs_s     = (state_r == CIS_XFER) & src_tvalid_s & m_tready_i;
    assign drain_last_s  = (state_r == CIS_DRAIN) & src_tvalid_s & src_tlast_s;
    // A tlast beat accepted in the abort cycle already ends the source stream
    assign src_end_now_s = src_end_r | (xfer_hs_s & src_tlast_s);

    // Zero-latency stream mux: pass-through in XFER, sink-all in DRAIN
    always_comb begin
        m_tvalid_o   = 1'b0;
        m_tdata_o    = 8'd0;
        m_tlast_o    = 1'b0;
        src_tready_s = 1'b0;
        case (state_r)
            CIS_XFER: begin
                m_tvalid_o   = src_tvalid_s;
                m_tdata_o    = src_tdata_s;
                m_tlast_o    = m_tlast_s;
                src_tready_s = m_tready_i;
            end
            CIS_DRAIN: begin
                src_tready_s = 1'b1;
            end
            default: begin
                src_tready_s = 1'b0;
            end
        endcase
        s0_tready_o = src_tready_s & ~sel_r;
        s1_tready_o = src_tready_s & sel_r;
    end

    // Next-state logic; abort_i outranks every other event
    always_comb begin
        state_s = state_r;
        case (state_r)
            CIS_IDLE: begin
                if (start_i) begin
                    state_s = (length_i == 16'd0) ? CIS_DRAIN : CIS_WAIT_IN;
                end else begin
                    state_s = CIS_IDLE;
                end
            end
            CIS_WAIT_IN: begin
                if (abort_i) begin
                    state_s = src_end_r ? CIS_IDLE : CIS_DRAIN;
                end else if (in_req_i) begin
                    state_s = CIS_XFER;
                end else begin
                    state_s = CIS_WAIT_IN;
                end
            end
            CIS_XFER: begin
                if (abort_i) begin
                    state_s = src_end_now_s ? CIS_IDLE : CIS_DRAIN;
                end else if (xfer_hs_s && m_tlast_s) begin
                    if (src_tlast_s) begin
                        state_s = CIS_DONE;
                    end else if (last_rem_s) begin
                        state_s = CIS_DRAIN;
                    end else begin
                        state_s = CIS_WAIT_IN;
                    end
                end else begin
                    state_s = CIS_XFER;
                end
            end
            CIS_DRAIN: begin
                if (drain_last_s) begin
                    state_s = (aborted_r || abort_i) ? CIS_IDLE : CIS_DONE;
                end else begin
                    state_s = CIS_DRAIN;
                end
            end
            CIS_DONE: begin
                state_s = CIS_IDLE;
            end
            default: begin
                state_s = CIS_IDLE;
            end
        endcase
    end

    // State register, byte counters and per-transfer flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= CIS_IDLE;
            remaining_r <= 16'd0;
            chunk_r     <= '0;
            sel_r       <= 1'b0;
            src_end_r   <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                CIS_IDLE: begin
                    if (start_i) begin
                        sel_r       <= (USE_EP_USER != 0) && (endp_i == EP_USER);
                        remaining_r <= length_i;
                        chunk_r     <= '0;
                        src_end_r   <= 1'b0;
                        aborted_r   <= 1'b0;
                    end
                end
                CIS_WAIT_IN: begin
                    if (abort_i) begin
                        aborted_r <= 1'b1;
                    end else if (in_req_i) begin
                        chunk_r <= '0;
                    end
                end
                CIS_XFER: begin
                    if (xfer_hs_s) begin
                        remaining_r <= remaining_r - 16'd1;
                        chunk_r     <= chunk_r + CW'(1);
                        if (src_tlast_s) begin
                            src_end_r <= 1'b1;
                        end
                    end
                    if (abort_i) begin
                        aborted_r <= 1'b1;
                    end
                end
                CIS_DRAIN: begin
                    if (abort_i) begin
                        aborted_r <= 1'b1;
                    end
                    if (drain_last_s) begin
                        src_end_r <= 1'b1;
                    end
                end
                default: begin
                    aborted_r <= aborted_r;
                end
            endcase
        end
    end

    assign busy_o = (state_r != CIS_IDLE);
    assign sel_o  = sel_r;
    assign done_o = (state_r == CIS_DONE);

`ifdef USB_CTL_ZLP_EN
    logic zlp_r;

    // Remember a source end on a full packet while wLength was not reached
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            zlp_r <= 1'b0;
        end else if ((state_r == CIS_IDLE) && start_i) begin
            zlp_r <= 1'b0;
        end else if (xfer_hs_s && src_tlast_s && !abort_i && last_chunk_s && !last_rem_s) begin
            zlp_r <= 1'b1;
        end else begin
            zlp_r <= zlp_r;
        end
    end

    assign zlp_o = zlp_r & (state_r == CIS_DONE);
`else
    assign zlp_o = 1'b0;
`endif

endmodule

// File: tb/tb_ctl_in_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ctl_in_sequencer
// Directed, table-driven bench for ctl_in_sequencer (default parameters:
// MAX_PACKET_SIZE=64, EP_USER=2, USE_EP_USER=1). Each table row describes a
// control transfer and its hand-computed outcome; a reset-mid-transfer
// sequence is written out by hand.
// ----------------------------------------------------------------------------
module tb_ctl_in_sequencer;

`ifdef USB_CTL_ZLP_EN
    localparam int ZLP_EXP = 1;
`else
    localparam int ZLP_EXP = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  endp_i;
    logic [15:0] length_i;
    logic        in_req_i;
    logic        abort_i;
    logic        s0_tvalid_i, s0_tready_o, s0_tlast_i;
    logic [7:0]  s0_tdata_i;
    logic        s1_tvalid_i, s1_tready_o, s1_tlast_i;
    logic [7:0]  s1_tdata_i;
    logic        m_tvalid_o, m_tready_i, m_tlast_o;
    logic [7:0]  m_tdata_o;
    logic        busy_o, sel_o, done_o, zlp_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ctl_in_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .endp_i      (endp_i),
        .length_i    (length_i),
        .in_req_i    (in_req_i),
        .abort_i     (abort_i),
        .s0_tvalid_i (s0_tvalid_i),
        .s0_tready_o (s0_tready_o),
        .s0_tlast_i  (s0_tlast_i),
        .s0_tdata_i  (s0_tdata_i),
        .s1_tvalid_i (s1_tvalid_i),
        .s1_tready_o (s1_tready_o),
        .s1_tlast_i  (s1_tlast_i),
        .s1_tdata_i  (s1_tdata_i),
        .m_tvalid_o  (m_tvalid_o),
        .m_tready_i  (m_tready_i),
        .m_tlast_o   (m_tlast_o),
        .m_tdata_o   (m_tdata_o),
        .busy_o      (busy_o),
        .sel_o       (sel_o),
        .done_o      (done_o),
        .zlp_o       (zlp_o)
    );

    typedef struct {
        int endp;
        int length;
        int src_len;
        int sel;        // stream the bench feeds, and expected sel_o
        int stall;      // random tvalid / tready stalls
        int abort_at;   // abort after this many output beats, -1 = never
        int exp_bytes;
        int exp_pkts;
        int exp_pkt0;
        int exp_last;   // last output beat carried tlast
        int exp_done;
        int exp_zlp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start_i = 1'b0; endp_i = 4'd0; length_i = 16'd0;
        in_req_i = 1'b0; abort_i = 1'b0;
        s0_tvalid_i = 1'b0; s0_tlast_i = 1'b0; s0_tdata_i = 8'd0;
        s1_tvalid_i = 1'b0; s1_tlast_i = 1'b0; s1_tdata_i = 8'd0;
        m_tready_i = 1'b0;
    endtask

    function automatic int out_bits();
        return int'({m_tvalid_o, m_tlast_o, m_tdata_o, s0_tready_o, s1_tready_o,
                     busy_o, sel_o, done_o, zlp_o});
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int src_idx = 0, out_cnt = 0, pkt_cnt = 0, cur_pkt = 0, pkt0_len = 0;
        int gap = 0, cyc = 0, done_cnt = 0, zlp_cnt = 0;
        int proto_err = 0, rdy_err = 0, data_err = 0, abort_stage = 0;
        bit in_pkt = 0, last_tlast = 0, src_hs = 0, m_hs = 0, m_last = 0;
        bit busy_s = 0, mval_after = 1, timed_out = 0, tv;
        logic [7:0] base;
        base = 8'(id * 16);
        @(posedge clock); #1;
        endp_i = 4'(v.endp); length_i = 16'(v.length); start_i = 1'b1;
        while (1) begin
            tv = (src_idx < v.src_len) && ((v.stall == 0) || ($urandom_range(0, 3) != 0));
            if (v.sel != 0) begin
                s1_tvalid_i = tv; s1_tdata_i = base + 8'(src_idx);
                s1_tlast_i = (src_idx == v.src_len - 1);
                s0_tvalid_i = 1'b1; s0_tdata_i = 8'hEE; s0_tlast_i = 1'b0;
            end else begin
                s0_tvalid_i = tv; s0_tdata_i = base + 8'(src_idx);
                s0_tlast_i = (src_idx == v.src_len - 1);
                s1_tvalid_i = 1'b1; s1_tdata_i = 8'hEE; s1_tlast_i = 1'b0;
            end
            m_tready_i = (v.stall == 0) || ($urandom_range(0, 2) != 0);
            if (abort_stage == 1) m_tready_i = 1'b0;

            @(negedge clock);
            src_hs = (v.sel != 0) ? (s1_tvalid_i & s1_tready_o) : (s0_tvalid_i & s0_tready_o);
            if ((v.sel != 0) ? s0_tready_o : s1_tready_o) rdy_err++;
            m_hs   = m_tvalid_o & m_tready_i;
            m_last = m_tlast_o;
            if (m_tvalid_o && !in_pkt) proto_err++;
            if (m_hs) begin
                if (m_tdata_o !== base + 8'(out_cnt)) data_err++;
                if (cur_pkt == 63 && !m_last) proto_err++;
            end
            if (done_o) done_cnt++;
            if (zlp_o) begin
                zlp_cnt++;
                if (!done_o) proto_err++;
            end
            busy_s = busy_o;
            if (abort_stage == 2) begin
                mval_after = m_tvalid_o;
                abort_stage = 3;
            end

            @(posedge clock); #1;
            start_i = 1'b0; in_req_i = 1'b0; abort_i = 1'b0;
            if (src_hs) src_idx++;
            if (m_hs) begin
                out_cnt++;
                last_tlast = m_last;
                if (m_last) begin
                    if (pkt_cnt == 0) pkt0_len = cur_pkt + 1;
                    pkt_cnt++; cur_pkt = 0; in_pkt = 0; gap = 0;
                end else begin
                    cur_pkt++;
                end
            end
            if (abort_stage == 1) abort_stage = 2;
            cyc++;
            if (src_idx >= v.src_len && !busy_s && cyc > 2) break;
            if (cyc > 3000) begin
                timed_out = 1;
                break;
            end
            if (!in_pkt) begin
                gap++;
                if (gap >= 3 && busy_s) begin
                    in_req_i = 1'b1;
                    in_pkt = 1;
                end
            end
            if (v.abort_at >= 0 && abort_stage == 0 && in_pkt && out_cnt == v.abort_at) begin
                abort_i = 1'b1; start_i = 1'b1; endp_i = 4'd2; length_i = 16'd100;
                abort_stage = 1;
            end
        end
        idle_inputs();
        check($sformatf("v%0d timeout", id), int'(timed_out), 0);
        check($sformatf("v%0d bytes", id), out_cnt, v.exp_bytes);
        check($sformatf("v%0d packets", id), pkt_cnt, v.exp_pkts);
        check($sformatf("v%0d pkt0_len", id), pkt0_len, v.exp_pkt0);
        check($sformatf("v%0d last_tlast", id), int'(last_tlast), v.exp_last);
        check($sformatf("v%0d done_cnt", id), done_cnt, v.exp_done);
        check($sformatf("v%0d zlp_cnt", id), zlp_cnt, v.exp_zlp);
        check($sformatf("v%0d sel", id), int'(sel_o), v.sel);
        check($sformatf("v%0d src_consumed", id), src_idx, v.src_len);
        check($sformatf("v%0d proto_err", id), proto_err, 0);
        check($sformatf("v%0d other_tready", id), rdy_err, 0);
        check($sformatf("v%0d data_err", id), data_err, 0);
        check($sformatf("v%0d busy_end", id), int'(busy_o), 0);
        if (v.abort_at >= 0) check($sformatf("v%0d tvalid_after_abort", id), int'(mval_after), 0);
    endtask

    task automatic reset_mid_xfer();
        int n = 0;
        @(posedge clock); #1;
        endp_i = 4'd2; length_i = 16'd200; start_i = 1'b1;
        s1_tvalid_i = 1'b1; s1_tdata_i = 8'h5A; s1_tlast_i = 1'b0;
        s0_tvalid_i = 1'b1; s0_tdata_i = 8'h33;
        m_tready_i = 1'b1;
        @(posedge clock); #1; start_i = 1'b0;
        @(posedge clock); #1; in_req_i = 1'b1;
        @(posedge clock); #1; in_req_i = 1'b0;
        for (int c = 0; c < 100 && n < 20; c++) begin
            @(negedge clock);
            if (m_tvalid_o && m_tready_i) n++;
        end
        check("rst pre_beats", n, 20);
        check("rst pre_tvalid", int'(m_tvalid_o), 1);
        #2 reset = 1'b0;
        #1 check("rst outputs_zero", out_bits(), 0);
        idle_inputs();
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        check("rst idle_after", out_bits(), 0);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        vecs[0] = '{0,  64,  18, 0, 0, -1,  18, 1, 18, 1, 1, 0};
        vecs[1] = '{0,   9,  32, 0, 0, -1,   9, 1,  9, 1, 1, 0};
        vecs[2] = '{2, 200, 150, 1, 0, -1, 150, 3, 64, 1, 1, 0};
        vecs[3] = '{2, 255, 128, 1, 0, -1, 128, 2, 64, 1, 1, ZLP_EXP};
        vecs[4] = '{2, 200, 150, 1, 1, -1, 150, 3, 64, 1, 1, 0};
        vecs[5] = '{0,   0,  10, 0, 0, -1,   0, 0,  0, 0, 1, 0};
        vecs[6] = '{3,  20,  20, 0, 1, -1,  20, 1, 20, 1, 1, 0};
        vecs[7] = '{2,  64, 100, 1, 1, -1,  64, 1, 64, 1, 1, 0};
        vecs[8] = '{0,  64,  40, 0, 0, 10,  10, 0,  0, 0, 0, 0};

        repeat (3) @(posedge clock);
        #1 check("reset outputs_zero", out_bits(), 0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        check("post_reset idle", out_bits(), 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
            repeat (2) @(posedge clock);
        end

        reset_mid_xfer();
        run_vec(vecs[2], 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctl_in_sequencer.md
Name: ctl_in_sequencer

Overview:
- Shares the control-IN data path to the transaction FSM between two sources: pipe0 descriptor ROM (EP0) and a user control endpoint.
- Selects the source per control transfer.
- Truncates the response to the SETUP wLength.
- Segments it into MAX_PACKET_SIZE data packets, one per IN token.
- Replaces the 2:1 control-stream mux slot in the USB control top level.

Parameters:
MAX_PACKET_SIZE, 64, control max packet bytes; power of two, 8..512
EP_USER, 2, endpoint number routed to source 1
USE_EP_USER, 1, 0 = source 1 never selected; s1_tready_o held 0

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
start_i  input  1  one-cycle strobe: SETUP decoded, IN data stage follows
endp_i  input  4  endpoint of the SETUP, sampled on start_i
length_i  input  16  wLength, sampled on start_i
in_req_i  input  1  one-cycle strobe: IN token for the active control pipe
abort_i  input  1  one-cycle strobe: new SETUP or bus reset
s0_tvalid_i / s0_tready_o / s0_tlast_i  in/out/in  1  pipe0 source stream
s0_tdata_i  input  8  pipe0 source data
s1_tvalid_i / s1_tready_o / s1_tlast_i  in/out/in  1  user endpoint source stream
s1_tdata_i  input  8  user source data
m_tvalid_o / m_tready_i / m_tlast_o  out/in/out  1  to transaction ctl_*_i stream
m_tdata_o  output  8  output data
busy_o  output  1  transfer active (state != IDLE)
sel_o  output  1  latched source select (1 = user endpoint)
done_o  output  1  one-cycle strobe: data stage complete
zlp_o  output  1  one-cycle strobe: zero-length packet required (feature-gated)

Behaviour:
- Reset (reset low, async):
  - State = IDLE; remaining = 0; chunk = 0; sel = 0.
  - All outputs 0.
- States: IDLE, WAIT_IN, XFER, DRAIN, DONE.
- IDLE:
  - On start_i, latch sel = USE_EP_USER && (endp_i == EP_USER), and remaining = length_i.
  - If length_i == 0, go to DRAIN (source still produces data), otherwise WAIT_IN.
  - start_i is ignored in every state other than IDLE.
- WAIT_IN: on in_req_i, set chunk = 0 and go to XFER.
- XFER:
  - Combinational pass-through of the selected source: m_tvalid_o = src_tvalid, src_tready = m_tready_i, m_tdata_o = src_tdata.
  - Unselected source tready is 0.
  - m_tlast_o = src_tlast | (chunk == MAX_PACKET_SIZE-1) | (remaining == 1).
  - On each m handshake: remaining -= 1, chunk += 1. Counter widths: 16 bits and clog2(MAX)+1 bits.
  - End of a packet (handshake with m_tlast_o = 1):
    - src_tlast → DONE.
    - Else remaining == 1 → DRAIN (truncated).
    - Else → WAIT_IN (next packet).
- DRAIN:
  - m_tvalid_o = 0; selected src_tready = 1; discard beats.
  - On a src_tlast handshake → DONE.
- DONE: assert done_o for one cycle, then IDLE.
- ZLP rule: the transfer ends on a full packet (chunk == MAX at end) by src_tlast with total < latched length → ZLP required (see Optional Feature).
- abort_i takes priority over all events in the same cycle:
  - From XFER or WAIT_IN, go to DRAIN if the source has not yet delivered tlast (tracked src_end flag), else IDLE.
  - No done_o is issued on abort.
  - An abort mid-packet leaves m_tlast_o unasserted; the transaction FSM discards the partial packet.
- Latency: zero-cycle data path; state transitions take effect the next clock.
- No beat is lost or duplicated under arbitrary tvalid/tready stalls.

Optional Feature:
- USB_CTL_ZLP_EN defined: zlp_o pulses with the done_o cycle when the ZLP rule holds. The transaction FSM answers the next IN with a zero-length DATAx.
- Undefined: zlp_o is constant 0; no ZLP logic is synthesised.

Decomposition:
- Shared package/include, usb_ctl_defs: state encodings (CIS_IDLE..CIS_DONE), the default max packet size constant, endpoint number constants.
- No sub-module: the mux is a few assigns. The counters and FSM stay in one block of ~200 lines.

Test Plan:
- Device descriptor from s0, 18 bytes with s0_tlast on byte 18; start_i(endp=0, length=64); one in_req_i → 18 bytes on m, tlast on byte 18, done_o once, s1_tready_o always 0.
- Config descriptor from s0, 32 bytes; length_i=9 → 9 bytes out, tlast on byte 9; remaining 23 drained with m_tvalid_o=0; done_o after the s0 tlast.
- s1 stream of 150 bytes; endp=2; length=200; MAX=64 → packets 64/64/22, each gated by in_req_i; no output between tlast and the next in_req_i.
- 128-byte s1 stream; length=255; USB_CTL_ZLP_EN defined → zlp_o=1 with done_o. Undefined → zlp_o=0.
- abort_i mid-packet at byte 10 of 40 → m_tvalid_o drops next cycle, 30 bytes drained, returns to IDLE, no done_o. A start_i in the same cycle as abort_i is ignored.
- Random m_tready_i/src_tvalid stalls plus reset asserted mid-XFER → outputs 0 immediately; byte count checked against a scoreboard.
